// File: rtl/mem_bus_ctrl_if.sv
// CPU-side bus of the memory/IO controller: request qualifiers in, one-cycle ready and read data out.
interface mem_bus_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              write_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic [DATA_W-1:0] data_out;

    modport master (output req, write_en, addr, data_in, input  ready, data_out);
    modport slave  (input  req, write_en, addr, data_in, output ready, data_out);
endinterface

// File: rtl/mem_bus_ctrl.sv
// Handshaked bus controller: decodes CPU accesses to internal RAM, sync ROM, IO channels and
// an input-change flag register, with per-target wait states and a one-cycle ready pulse.
module mem_bus_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                RAM_AW   = 12,
    parameter logic [ADDR_W-1:0] RAM_BASE = 16'hF000,
    parameter int                ROM_AW   = 13,
    parameter logic [ADDR_W-1:0] IO_BASE  = 16'h2000,
    parameter int                IO_CH    = 2,
    parameter int                WAIT_ROM = 1,
    parameter int                WAIT_RAM = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_bus_ctrl_if.slave           bus,
    output logic [ROM_AW-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    input  logic [IO_CH*DATA_W-1:0] io_inputs,
    output logic [IO_CH*DATA_W-1:0] io_outputs
);
    localparam int WMAX  = (WAIT_ROM > WAIT_RAM) ? WAIT_ROM : WAIT_RAM;
    localparam int CNT_W = (WMAX > 0) ? $clog2(WMAX + 1) : 1;
    localparam int CH_W  = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam int AW1   = ADDR_W + 1;

    // Window limits carry one extra bit so a RAM window ending at the top of memory does not wrap.
    localparam logic [AW1-1:0]    RAM_LO  = {1'b0, RAM_BASE};
    localparam logic [AW1-1:0]    RAM_HI  = RAM_LO + AW1'(2 ** RAM_AW);
    localparam logic [AW1-1:0]    ROM_HI  = AW1'(2 ** ROM_AW);
    localparam logic [ADDR_W-1:0] IO_N    = ADDR_W'(IO_CH);
    localparam logic [ADDR_W-1:0] IO_SPAN = ADDR_W'(2 * IO_CH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_e;
    typedef enum logic [2:0] {T_RAM, T_IN, T_OUT, T_FLG, T_ROM, T_NONE} tgt_e;

    state_e                         state;
    tgt_e                           tgt_q, dec_tgt;
    logic [CH_W-1:0]                ch_q, dec_ch;
    logic [CNT_W-1:0]               wcnt;
    logic [ADDR_W-1:0]              lat_addr;
    logic [DATA_W-1:0]              lat_data;
    logic                           lat_we;
    logic                           ready_q;
    logic [DATA_W-1:0]              data_out_q;
    logic [IO_CH-1:0][DATA_W-1:0]   out_q;
    logic [IO_CH-1:0][DATA_W-1:0]   samp_q;
    logic [IO_CH-1:0][DATA_W-1:0]   in_v;
    logic [IO_CH-1:0]               flags_q, chg;
    logic [DATA_W-1:0]              rd_data;
    logic [AW1-1:0]                 addr_x;
    logic [ADDR_W-1:0]              io_off;
    logic [RAM_AW-1:0]              ram_idx;
    logic                           ram_we;
    logic [DATA_W-1:0]              ram [2**RAM_AW];

    assign in_v         = io_inputs;
    assign io_outputs   = out_q;
    assign rom_addr     = lat_addr[ROM_AW-1:0];
    assign bus.ready    = ready_q;
    assign bus.data_out = data_out_q;
    assign ram_idx      = RAM_AW'(lat_addr - RAM_BASE);

    for (genvar k = 0; k < IO_CH; k++) begin : g_chg
        assign chg[k] = (in_v[k] != samp_q[k]);
    end

    // Priority decode: RAM, then IO window (exact offsets only), then ROM, else unmapped.
    always_comb begin
        addr_x  = {1'b0, bus.addr};
        io_off  = bus.addr - IO_BASE;
        dec_tgt = T_NONE;
        dec_ch  = '0;
        if (addr_x >= RAM_LO && addr_x < RAM_HI) begin
            dec_tgt = T_RAM;
        end else if (bus.addr >= IO_BASE && io_off <= IO_SPAN) begin
            if (io_off < IO_N) begin
                dec_tgt = T_IN;
                dec_ch  = CH_W'(io_off);
            end else if (io_off < IO_SPAN) begin
                dec_tgt = T_OUT;
                dec_ch  = CH_W'(io_off - IO_N);
            end else begin
                dec_tgt = T_FLG;
            end
        end else if (addr_x < ROM_HI) begin
            dec_tgt = T_ROM;
        end
    end

    always_comb begin
        rd_data = '0;
        case (tgt_q)
            T_RAM:   rd_data = ram[ram_idx];
            T_IN:    rd_data = samp_q[ch_q];
            T_OUT:   rd_data = out_q[ch_q];
            T_FLG:   rd_data = DATA_W'(flags_q);
            T_ROM:   rd_data = rom_data;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            tgt_q      <= T_NONE;
            ch_q       <= '0;
            wcnt       <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_we     <= 1'b0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
            out_q      <= '0;
            samp_q     <= '0;
            flags_q    <= '0;
        end else begin
            samp_q  <= in_v;
            flags_q <= flags_q | chg;
            ready_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        lat_addr <= bus.addr;
                        lat_data <= bus.data_in;
                        lat_we   <= bus.write_en;
                        tgt_q    <= dec_tgt;
                        ch_q     <= dec_ch;
                        wcnt     <= (dec_tgt == T_ROM) ? CNT_W'(WAIT_ROM) : CNT_W'(WAIT_RAM);
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (wcnt == '0) begin
                        state   <= S_ACK;
                        ready_q <= 1'b1;
                        if (lat_we) begin
                            if (tgt_q == T_OUT) out_q[ch_q] <= lat_data;
                        end else begin
                            data_out_q <= rd_data;
                            // A change seen on the clearing edge keeps its flag.
                            if (tgt_q == T_FLG) flags_q <= chg;
                        end
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM has no reset; a reset mid-access forces IDLE first, so the write never lands.
    assign ram_we = (state == S_BUSY) && (wcnt == '0) && lat_we && (tgt_q == T_RAM);

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= lat_data;
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: driver pushes model expectations, negedge monitor checks them.
module tb_mem_bus_ctrl;
    localparam int W_ROM = 2;
    localparam int W_RAM = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] rom_addr;
    logic [15:0] rom_data;
    logic [31:0] io_in;
    logic [31:0] io_out;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_bus_ctrl #(
        .DATA_W(16), .ADDR_W(16), .RAM_AW(12), .RAM_BASE(16'hF000), .ROM_AW(13),
        .IO_BASE(16'h2000), .IO_CH(2), .WAIT_ROM(W_ROM), .WAIT_RAM(W_RAM)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .rom_addr(rom_addr), .rom_data(rom_data),
        .io_inputs(io_in), .io_outputs(io_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // ROM model: one-cycle synchronous read returning address+1.
    always @(posedge clk) rom_data <= {3'b000, rom_addr} + 16'd1;

    typedef struct {
        bit          chk;
        logic [15:0] data;
        int          acc;
        int          lat;
        string       name;
    } exp_t;
    exp_t sbq[$];

    // Reference model state
    logic [15:0] m_ram [4096];
    bit          m_ok  [4096];
    logic [15:0] m_out [2];
    logic [15:0] cur_in [2];
    logic [1:0]  m_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input int ch, input logic [15:0] v);
        if (v != cur_in[ch]) m_flags[ch] = 1'b1;
        cur_in[ch] = v;
        io_in[ch*16 +: 16] = v;
    endtask

    // Issue one access; optional input toggle lands on the edge after accept.
    task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d,
                          input string name, input int tog_ch = -1, input logic [15:0] tog_val = 0);
        exp_t e;
        bit   done;
        int   off;
        int   idx;
        e.chk = !we; e.data = 16'h0; e.lat = W_RAM; e.name = name; e.acc = 0;
        if (a >= 16'hF000) begin
            idx = int'(a - 16'hF000);
            if (we) begin m_ram[idx] = d; m_ok[idx] = 1'b1; end
            else begin e.data = m_ram[idx]; e.chk = m_ok[idx]; end
        end else if (a >= 16'h2000 && a <= 16'h2004) begin
            off = int'(a - 16'h2000);
            if (off < 2) e.data = cur_in[off];
            else if (off < 4) begin
                if (we) m_out[off-2] = d;
                e.data = m_out[off-2];
            end else begin
                e.data = {14'b0, m_flags};
                if (!we) m_flags = 2'b00;
            end
        end else if (a < 16'h2000) begin
            e.data = a + 16'd1;
            e.lat  = W_ROM;
        end
        @(negedge clk);
        bus.req = 1'b1; bus.write_en = we; bus.addr = a; bus.data_in = d;
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        bus.req = 1'b0; bus.write_en = 1'($urandom); bus.addr = 16'($urandom); bus.data_in = 16'($urandom);
        if (tog_ch >= 0) set_in(tog_ch, tog_val);
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ready === 1'b1) begin done = 1'b1; break; end
            @(negedge clk);
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s timeout: no ready within 20 cycles, required one", name);
        end
    endtask

    task automatic model_reset();
        m_out[0] = 16'h0; m_out[1] = 16'h0;
        m_flags = {cur_in[1] != 16'h0, cur_in[0] != 16'h0};
    endtask

    // Monitor: every ready pulse must match the oldest pending expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && bus.ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat + 1));
                if (e.chk) check({e.name, "_data"}, {16'h0, bus.data_out}, {16'h0, e.data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] v;
        int          cls;
        bus.req = 1'b0; bus.write_en = 1'b0; bus.addr = 16'h0; bus.data_in = 16'h0;
        io_in = 32'h0; cur_in[0] = 16'h0; cur_in[1] = 16'h0;
        m_out[0] = 16'h0; m_out[1] = 16'h0; m_flags = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'h0);
        check("rst_data_out", {16'h0, bus.data_out}, 32'h0);
        check("rst_io_out", io_out, 32'h0);
        reset = 1'b0;
        model_reset();

        access(1'b1, 16'hF005, 16'hBEEF, "ram_wr");
        access(1'b0, 16'hF005, 16'h0000, "ram_rd");
        access(1'b0, 16'h0123, 16'h0000, "rom_rd");
        check("rom_addr", {19'b0, rom_addr}, 32'h0123);
        access(1'b1, 16'h2003, 16'h00A5, "out1_wr");
        check("io_out_ch1", {16'h0, io_out[31:16]}, 32'h00A5);
        access(1'b0, 16'h2003, 16'h0000, "out1_rd");
        set_in(1, 16'h1234);
        access(1'b0, 16'h2001, 16'h0000, "in1_rd");
        access(1'b0, 16'h2004, 16'h0000, "flags_ch1");
        set_in(0, 16'h0001);
        access(1'b0, 16'h2004, 16'h0000, "flags_ch0");
        access(1'b0, 16'h2004, 16'h0000, "flags_cleared");
        access(1'b0, 16'h2004, 16'h0000, "flags_tog_read", 0, 16'h0000);
        access(1'b0, 16'h2004, 16'h0000, "flags_tog_kept");

        access(1'b1, 16'h8000, 16'h1111, "unmapped_wr");
        access(1'b1, 16'h0010, 16'h2222, "rom_wr");
        access(1'b1, 16'h2004, 16'h3333, "flags_wr");
        check("io_out_after_drops", io_out, {m_out[1], m_out[0]});
        access(1'b0, 16'h8000, 16'h0000, "unmapped_rd");
        access(1'b0, 16'h0010, 16'h0000, "rom_rd_after_wr");
        access(1'b0, 16'h2005, 16'h0000, "io_edge_unmapped");
        access(1'b0, 16'h1FFF, 16'h0000, "rom_top");
        access(1'b1, 16'hFFFF, 16'h5A5A, "ram_top_wr");
        access(1'b1, 16'hF000, 16'hA5A5, "ram_bot_wr");
        access(1'b0, 16'hFFFF, 16'h0000, "ram_top_rd");
        access(1'b0, 16'hF000, 16'h0000, "ram_bot_rd");
        access(1'b0, 16'h2003, 16'h0000, "out1_rd_pre_rst");

        // Reset while a RAM write sits in BUSY: it must be abandoned without a ready pulse.
        @(negedge clk);
        bus.req = 1'b1; bus.write_en = 1'b1; bus.addr = 16'hF005; bus.data_in = 16'h5555;
        @(negedge clk);
        bus.req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'b0, bus.ready}, 32'h0);
        check("abort_data_out", {16'h0, bus.data_out}, 32'h0);
        check("abort_io_out", io_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        access(1'b0, 16'hF005, 16'h0000, "ram_after_abort");
        access(1'b0, 16'h2004, 16'h0000, "flags_after_rst");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) set_in(int'($urandom_range(0, 1)), 16'($urandom_range(0, 3)));
            cls = int'($urandom_range(0, 3));
            case (cls)
                0: a = ($urandom_range(0, 1) == 1) ? 16'hF000 + 16'($urandom_range(0, 15))
                                                   : 16'hFFF0 + 16'($urandom_range(0, 15));
                1: a = 16'h2000 + 16'($urandom_range(0, 5));
                2: a = 16'($urandom_range(0, 16'h1FFF));
                default: a = 16'($urandom_range(16'h2006, 16'hEFFF));
            endcase
            v = 16'($urandom);
            access(1'($urandom_range(0, 1)), a, v, "rand");
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
